// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: oversampling UART receiver. It detects the start bit, shifts in
// DATA_W data bits LSB-first, then an optional parity bit and one stop bit.
// The received word is presented with a one-cycle DATA_VALID strobe. Parity
// and framing errors are reported as one-cycle strobes.
//
// Build option: define UART_RX_MAJ_VOTE_EN to take each bit value as the
// majority of three consecutive samples around mid-bit. The decision point
// and the completion strobes then move one cycle later. Without the macro,
// each bit is a single sample at edge_cnt == OVS/2-1.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | line idle, waiting for a falling edge; counters held at zero
// START  | inside the start bit; a high mid-bit sample means a glitch
// DATA   | shifting in DATA_W data bits, LSB first
// PARITY | checking the parity bit against the received data
// STOP   | sampling the stop bit; leaves at mid-bit to catch the next start
module uart_rx_fsm #(
  parameter int DATA_W = 8,
  parameter int OVS    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic [DATA_W-1:0] P_DATA,
  output logic              DATA_VALID,
  output logic              PAR_ERR,
  output logic              STP_ERR,
  output logic              BUSY
);

  localparam int EC_W = $clog2(OVS);
  localparam int BC_W = $clog2(DATA_W + 1);

  localparam logic [EC_W-1:0] LAST_EC  = EC_W'(OVS - 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

`ifdef UART_RX_MAJ_VOTE_EN
  // With voting, the third sample arrives at OVS/2. The bit is decided there.
  localparam logic [EC_W-1:0] SAMPLE_EC = EC_W'(OVS / 2);
`else
  localparam logic [EC_W-1:0] SAMPLE_EC = EC_W'(OVS / 2 - 1);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  logic [EC_W-1:0]   edge_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              par_en_q;
  logic              par_typ_q;
  logic              par_bad;

  logic sample_pt;
  logic wrap;
  logic last_bit;
  logic bit_val;
  logic exp_par;

  assign sample_pt = (edge_cnt == SAMPLE_EC);
  assign wrap      = (edge_cnt == LAST_EC);
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign exp_par   = (^shift) ^ par_typ_q;

`ifdef UART_RX_MAJ_VOTE_EN
  // hist[1] holds the sample from two cycles ago and hist[0] the sample from
  // the previous cycle. Together with the live input they form the 3-sample vote.
  logic [1:0] hist;

  // Sample history for the majority vote
  always_ff @(posedge CLK) begin
    if (RST) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], RX_IN};
    end
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & RX_IN) | (hist[0] & RX_IN);
`else
  assign bit_val = RX_IN;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!RX_IN) begin
          next_state = START;
        end
      end
      START: begin
        if (sample_pt && bit_val) begin
          next_state = IDLE;
        end else if (wrap) begin
          next_state = DATA;
        end
      end
      DATA: begin
        if (wrap && last_bit) begin
          next_state = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (wrap) begin
          next_state = STOP;
        end
      end
      STOP: begin
        // Returning at mid-stop-bit leaves half a bit to see the next start edge.
        if (sample_pt) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Bit timing counters, frame config latch, shift register and parity check
  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          edge_cnt <= '0;
          bit_cnt  <= '0;
          // Freeze the parity settings for the whole frame at the start edge.
          if (!RX_IN) begin
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_bad   <= 1'b0;
          end
        end
        START: begin
          edge_cnt <= wrap ? '0 : edge_cnt + EC_W'(1);
          bit_cnt  <= '0;
        end
        DATA: begin
          edge_cnt <= wrap ? '0 : edge_cnt + EC_W'(1);
          if (wrap) begin
            bit_cnt <= bit_cnt + BC_W'(1);
          end
          if (sample_pt) begin
            shift <= {bit_val, shift[DATA_W-1:1]};
          end
        end
        PARITY: begin
          edge_cnt <= wrap ? '0 : edge_cnt + EC_W'(1);
          if (sample_pt) begin
            par_bad <= (bit_val != exp_par);
          end
        end
        STOP: begin
          edge_cnt <= wrap ? '0 : edge_cnt + EC_W'(1);
        end
        default: begin
          edge_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  // Frame completion: update the word or flag errors, one cycle after the stop sample
  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (state == STOP && sample_pt) begin
        if (bit_val && !par_bad) begin
          P_DATA     <= shift;
          DATA_VALID <= 1'b1;
        end
        PAR_ERR <= par_bad;
        STP_ERR <= !bit_val;
      end
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed, table-driven bench for uart_rx_fsm (DATA_W=8, OVS=8).
// Frames are driven bit by bit. Each bit lasts OVS clocks. A negedge monitor
// counts strobes and records when they occur.
module tb_uart_rx_fsm;

  localparam int OVS = 8;
`ifdef UART_RX_MAJ_VOTE_EN
  localparam int VOTE_DLY = 1;
`else
  localparam int VOTE_DLY = 0;
`endif

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  uart_rx_fsm #(.DATA_W(8), .OVS(OVS)) dut (
    .CLK       (clk),
    .RST       (rst),
    .RX_IN     (rx_in),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .P_DATA    (p_data),
    .DATA_VALID(data_valid),
    .PAR_ERR   (par_err),
    .STP_ERR   (stp_err),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int dv_n = 0, pe_n = 0, se_n = 0, busy_n = 0;
  int strobe_cyc = 0, dv_cyc = 0, dv_prev_cyc = 0;
  logic [7:0] dv_data = '0, dv_prev_data = '0;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_n++;
      dv_prev_cyc  = dv_cyc;
      dv_prev_data = dv_data;
      dv_cyc       = cyc;
      dv_data      = p_data;
    end
    if (pe_n >= 0 && par_err) pe_n++;
    if (stp_err) se_n++;
    if (busy) busy_n++;
    if (data_valid || par_err || stp_err) strobe_cyc = cyc;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic drive_bit(input logic b, input logic glitch);
    rx_in = b;
    if (glitch) begin
      repeat (OVS / 2 - 1) @(posedge clk);
      #1 rx_in = ~b;
      @(posedge clk);
      #1 rx_in = b;
      repeat (OVS / 2) @(posedge clk);
      #1;
    end else begin
      repeat (OVS) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic flip, input logic stp, input int glitch_idx,
                            output int start_c);
    start_c = cyc + 1;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], glitch_idx == i);
    if (pe) drive_bit((^d) ^ pt ^ flip, 1'b0);
    drive_bit(stp, 1'b0);
  endtask

  task automatic idle_wait(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       flip;
    logic       stp;
    int         exp_dv;
    int         exp_pe;
    int         exp_se;
    logic [7:0] exp_pdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int s0, s1, d0, p0, e0, b0, lat;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h3C};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 0, 8'h3C};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'h3C};
    vecs[4] = '{8'h96, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 0, 8'h96};
    vecs[5] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 1, 8'h96};
    vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0, 8'h00};
    vecs[7] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hFF};

    rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset p_data", p_data, 0);
    check("reset data_valid", data_valid, 0);
    check("reset par_err", par_err, 0);
    check("reset stp_err", stp_err, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    idle_wait(4);

    // Table of single frames (T1..T3 plus extra parity/data patterns)
    for (int v = 0; v < 8; v++) begin
      par_en = vecs[v].pe; par_typ = vecs[v].pt;
      d0 = dv_n; p0 = pe_n; e0 = se_n;
      send_frame(vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].flip, vecs[v].stp, -1, s0);
      par_en = ~par_en; par_typ = ~par_typ;
      idle_wait(2 * OVS);
      lat = (1 + 8 + int'(vecs[v].pe)) * OVS + OVS / 2 + VOTE_DLY;
      check($sformatf("vec%0d data_valid count", v), dv_n - d0, vecs[v].exp_dv);
      check($sformatf("vec%0d par_err count", v), pe_n - p0, vecs[v].exp_pe);
      check($sformatf("vec%0d stp_err count", v), se_n - e0, vecs[v].exp_se);
      check($sformatf("vec%0d p_data", v), p_data, vecs[v].exp_pdata);
      check($sformatf("vec%0d strobe latency", v), strobe_cyc - s0, lat);
      check($sformatf("vec%0d busy idle", v), busy, 0);
    end

    // T4: start glitch, then a normal frame
    par_en = 1'b0; par_typ = 1'b0;
    d0 = dv_n; p0 = pe_n; e0 = se_n; b0 = busy_n;
    rx_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_in = 1'b1;
    idle_wait(3 * OVS);
    check("glitch busy cycles", busy_n - b0, 4 + VOTE_DLY);
    check("glitch strobes", (dv_n - d0) + (pe_n - p0) + (se_n - e0), 0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, -1, s0);
    idle_wait(2 * OVS);
    check("after glitch data_valid count", dv_n - d0, 1);
    check("after glitch p_data", p_data, 8'h0F);

    // T5: back-to-back frames without idle gap
    d0 = dv_n;
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, -1, s0);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, -1, s1);
    idle_wait(2 * OVS);
    check("b2b data_valid count", dv_n - d0, 2);
    check("b2b spacing", dv_cyc - dv_prev_cyc, 80);
    check("b2b first word", dv_prev_data, 8'h01);
    check("b2b second word", dv_data, 8'hFE);
    check("b2b second latency", dv_cyc - s1, 76 + VOTE_DLY);

    // T6: reset in the middle of the data bits of 0x77
    d0 = dv_n; p0 = pe_n; e0 = se_n;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    check("mid-frame busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid reset p_data", p_data, 0);
    check("mid reset data_valid", data_valid, 0);
    check("mid reset busy", busy, 0);
    check("mid reset errors", par_err | stp_err, 0);
    rst = 1'b0;
    idle_wait(12 * OVS);
    check("mid reset strobes", (dv_n - d0) + (pe_n - p0) + (se_n - e0), 0);
    send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, -1, s0);
    idle_wait(2 * OVS);
    check("post reset p_data", p_data, 8'h77);

`ifdef UART_RX_MAJ_VOTE_EN
    // One-cycle glitch at the mid-bit sample is outvoted
    d0 = dv_n;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 3, s0);
    idle_wait(2 * OVS);
    check("vote data_valid count", dv_n - d0, 1);
    check("vote p_data", p_data, 8'h5A);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
